// File: rtl/pixel_stream_proc.sv
// Streaming pixel processor: per-frame selectable point operation through a
// 2-stage valid/ready pipeline, with end-of-line / end-of-frame tagging.
module pixel_stream_proc #(
    parameter int CHANNELS     = 3,
    parameter int CHANNEL_SIZE = 8,
    parameter int DIM_BITS     = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             en,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [CHANNEL_SIZE-1:0]          threshold,
    input  logic [DIM_BITS-1:0]              cfg_width,
    input  logic [DIM_BITS-1:0]              cfg_height,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*CHANNEL_SIZE-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*CHANNEL_SIZE-1:0] out_data,
    output logic                             out_eol,
    output logic                             out_eof,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int PW = CHANNELS * CHANNEL_SIZE;
    localparam logic [CHANNEL_SIZE-1:0] MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
    typedef enum logic [1:0] {OP_PASS, OP_INVERT, OP_GRAY, OP_THRESH} op_e;

    state_e                  state_q, state_d;
    op_e                     mode_q, mode_d;
    logic [CHANNEL_SIZE-1:0] thr_q, thr_d;
    logic [DIM_BITS-1:0]     width_q, width_d;
    logic [DIM_BITS-1:0]     height_q, height_d;
    logic [DIM_BITS-1:0]     col_q, col_d;
    logic [DIM_BITS-1:0]     row_q, row_d;

    logic                    s1_valid_q, s1_valid_d;
    logic [PW-1:0]           s1_data_q, s1_data_d;
    logic                    s1_eol_q, s1_eol_d;
    logic                    s1_eof_q, s1_eof_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [PW-1:0]           s2_data_q, s2_data_d;
    logic                    s2_eol_q, s2_eol_d;
    logic                    s2_eof_q, s2_eof_d;

    logic                    adv;
    logic                    accept;
    logic                    out_xfer;
    logic                    last_col;
    logic                    last_row;
    logic [CHANNEL_SIZE-1:0] luma;
    logic [CHANNEL_SIZE-1:0] ch;
    logic [PW-1:0]           op_result;

    // Handshake and frame position
    always_comb begin
        adv        = en & (~s2_valid_q | out_ready);
        in_ready   = adv & (state_q == ST_RUN);
        accept     = in_valid & in_ready;
        out_xfer   = en & s2_valid_q & out_ready;
        last_col   = (col_q == width_q - DIM_BITS'(1));
        last_row   = (row_q == height_q - DIM_BITS'(1));
        frame_done = out_xfer & s2_eof_q & (state_q == ST_DRAIN);
        busy       = (state_q != ST_IDLE);
        out_valid  = s2_valid_q;
        out_data   = s2_data_q;
        out_eol    = s2_eol_q;
        out_eof    = s2_eof_q;
    end

    // Luma weights B + 2G + R in a 2-bit wider sum so 4*MAX cannot overflow.
    if (CHANNELS >= 3) begin : g_luma_rgb
        logic [CHANNEL_SIZE+1:0] sum;
        always_comb begin
            sum  = {2'b00, s1_data_q[0 +: CHANNEL_SIZE]}
                 + {1'b0, s1_data_q[CHANNEL_SIZE +: CHANNEL_SIZE], 1'b0}
                 + {2'b00, s1_data_q[2*CHANNEL_SIZE +: CHANNEL_SIZE]};
            luma = CHANNEL_SIZE'(sum >> 2);
        end
    end else begin : g_luma_mono
        always_comb luma = s1_data_q[CHANNEL_SIZE-1:0];
    end

    always_comb begin
        op_result = s1_data_q;
        ch        = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ch = s1_data_q[k*CHANNEL_SIZE +: CHANNEL_SIZE];
            // The alpha byte of a BGRA pixel is never altered.
            if (!(CHANNELS == 4 && k == 3)) begin
                case (mode_q)
                    OP_INVERT: op_result[k*CHANNEL_SIZE +: CHANNEL_SIZE] = MAX - ch;
                    OP_GRAY:   op_result[k*CHANNEL_SIZE +: CHANNEL_SIZE] = luma;
                    OP_THRESH: op_result[k*CHANNEL_SIZE +: CHANNEL_SIZE] =
                                   (luma >= thr_q) ? MAX : '0;
                    default:   op_result[k*CHANNEL_SIZE +: CHANNEL_SIZE] = ch;
                endcase
            end
        end
    end

    // Frame FSM and counters
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path through the case infers a latch.
        state_d  = state_q;
        mode_d   = mode_q;
        thr_d    = thr_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        case (state_q)
            ST_IDLE: begin
                if (en && start && cfg_width != '0 && cfg_height != '0) begin
                    mode_d   = op_e'(mode);
                    thr_d    = threshold;
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    col_d    = '0;
                    row_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + DIM_BITS'(1);
                        end
                    end else begin
                        col_d = col_q + DIM_BITS'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (frame_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Both stages advance together; data registers only load real pixels so
    // the visible outputs hold their last value across bubbles.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_eol_d   = s1_eol_q;
        s1_eof_d   = s1_eof_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_eol_d   = s2_eol_q;
        s2_eof_d   = s2_eof_q;
        if (adv) begin
            s1_valid_d = accept;
            s1_eol_d   = accept & last_col;
            s1_eof_d   = accept & last_col & last_row;
            if (accept) s1_data_d = in_data;
            s2_valid_d = s1_valid_q;
            s2_eol_d   = s1_eol_q;
            s2_eof_d   = s1_eof_q;
            if (s1_valid_q) s2_data_d = op_result;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, because out_data must read zero after reset.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= OP_PASS;
            thr_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_eol_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_eol_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            mode_q     <= mode_d;
            thr_q      <= thr_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_eol_q   <= s1_eol_d;
            s1_eof_q   <= s1_eof_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_eol_q   <= s2_eol_d;
            s2_eof_q   <= s2_eof_d;
        end
    end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Directed bench for pixel_stream_proc: a 3-channel DUT and a 4-channel (BGRA)
// DUT driven in lockstep, the latter with a constant alpha byte.
module tb_pixel_stream_proc;

    localparam logic [7:0] ALPHA = 8'h5A;

    logic        clk = 1'b0;
    logic        reset_n, en, start;
    logic [1:0]  mode;
    logic [7:0]  threshold;
    logic [15:0] cfg_width, cfg_height;
    logic        in_valid, out_ready;
    logic [23:0] in_data;
    logic [31:0] in_data4;

    logic        in_ready, out_valid, out_eol, out_eof, busy, frame_done;
    logic [23:0] out_data;
    logic        in_ready4, out_valid4, out_eol4, out_eof4, busy4, frame_done4;
    logic [31:0] out_data4;

    int errors = 0;
    int checks = 0;

    logic [23:0] pix_a [16];
    logic [23:0] exp_a [16];

    typedef struct {
        string       name;
        logic [1:0]  md;
        logic [7:0]  thr;
        logic [23:0] pix;
        logic [23:0] expv;
    } vec_t;

    vec_t vecs [8];

    assign in_data4 = {ALPHA, in_data};

    always #5 clk = ~clk;

    pixel_stream_proc dut (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start), .mode(mode),
        .threshold(threshold), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .frame_done(frame_done)
    );

    pixel_stream_proc #(.CHANNELS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start), .mode(mode),
        .threshold(threshold), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_eol(out_eol4), .out_eof(out_eof4), .busy(busy4), .frame_done(frame_done4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame of w*h pixels from pix_a, checking every output transfer
    // against exp_a. Options: out_ready stall pattern, a 5-cycle en freeze after
    // 3 acceptances, and a start pulse plus mode change in the middle of the frame.
    task automatic run_frame(input int w, input int h, input logic [1:0] md,
                             input logic [7:0] thr, input bit stall,
                             input bit freeze, input bit disturb);
        int          n, sent, recv, cyc;
        int          acc_cyc [16];
        bit          timing, frozen, xfer, prev_stall;
        logic [23:0] prev_data, snap_data;
        logic        snap_valid, snap_eol;
        bit          pattern [4];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        n = w * h;
        timing = !stall && !freeze;
        frozen = 0;
        prev_stall = 0;
        prev_data = '0;
        sent = 0;
        recv = 0;
        cyc = 0;
        mode = md;
        threshold = thr;
        cfg_width = 16'(w);
        cfg_height = 16'(h);
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", {busy4, busy}, 2'b11);
        while (recv < n && cyc < 200) begin
            if (freeze && sent == 3 && !frozen) begin
                frozen = 1;
                snap_data = out_data;
                snap_valid = out_valid;
                snap_eol = out_eol;
                en = 1'b0;
                in_valid = 1'b1;
                in_data = pix_a[sent];
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    check("freeze_in_ready", in_ready, 1'b0);
                    step();
                    check("freeze_out_data", out_data, snap_data);
                    check("freeze_out_valid", out_valid, snap_valid);
                    check("freeze_out_eol", out_eol, snap_eol);
                    check("freeze_busy", busy, 1'b1);
                end
                en = 1'b1;
            end
            in_valid = 1'b1;
            in_data = (sent < n) ? pix_a[sent] : 24'hDEAD00;
            out_ready = stall ? pattern[cyc % 4] : 1'b1;
            if (disturb && sent == 2) begin
                start = 1'b1;
                mode = ~md;
                cfg_width = 16'd1;
                cfg_height = 16'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (sent >= n) check("no_accept_after_eof", {in_ready4, in_ready}, 2'b00);
            else if (in_valid && in_ready) begin
                acc_cyc[sent] = cyc;
                sent++;
            end
            if (prev_stall) check("stall_stable", out_data, prev_data);
            xfer = out_valid && out_ready;
            check("frame_done", {frame_done4, frame_done}, {2{xfer && recv == n - 1}});
            if (xfer) begin
                check("out_data", out_data, exp_a[recv]);
                check("out_data4", out_data4, {ALPHA, exp_a[recv]});
                check("out_eol", {out_eol4, out_eol}, {2{(recv % w) == w - 1}});
                check("out_eof", {out_eof4, out_eof}, {2{recv == n - 1}});
                check("out_valid4", out_valid4, 1'b1);
                if (timing) check("latency", 32'(cyc - acc_cyc[recv]), 32'd2);
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            step();
            cyc++;
        end
        check("frame_transfers", 32'(recv), 32'(n));
        start = 1'b0;
        in_valid = 1'b0;
        check("busy_after_done", {busy4, busy}, 2'b00);
        check("out_valid_after_done", out_valid, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        threshold = 8'd0;
        cfg_width = 16'd0;
        cfg_height = 16'd0;
        in_valid = 1'b1;
        in_data = 24'hABCDEF;
        out_ready = 1'b1;

        // Reset with a pixel offered
        step();
        step();
        check("rst_in_ready", {in_ready4, in_ready}, 2'b00);
        check("rst_out_valid", {out_valid4, out_valid}, 2'b00);
        check("rst_busy", {busy4, busy}, 2'b00);
        check("rst_out_data", out_data, 24'h0);
        check("rst_tags", {out_eol, out_eof, frame_done}, 3'b000);
        reset_n = 1'b1;
        repeat (3) step();
        check("idle_in_ready", in_ready, 1'b0);
        check("idle_busy", busy, 1'b0);
        in_valid = 1'b0;

        // Passthrough 4x2
        for (int i = 0; i < 8; i++) begin
            pix_a[i] = 24'(i + 1);
            exp_a[i] = 24'(i + 1);
        end
        run_frame(4, 2, 2'd0, 8'd0, 0, 0, 0);

        // Per-pixel operation vectors, each as a 1x1 frame
        vecs[0] = '{"pass",     2'd0, 8'h00, 24'h4080C0, 24'h4080C0};
        vecs[1] = '{"invert",   2'd1, 8'h00, 24'h4080C0, 24'hBF7F3F};
        vecs[2] = '{"gray",     2'd2, 8'h00, 24'h4080C0, 24'h808080};
        vecs[3] = '{"thr_81",   2'd3, 8'h81, 24'h4080C0, 24'h000000};
        vecs[4] = '{"thr_80",   2'd3, 8'h80, 24'h4080C0, 24'hFFFFFF};
        vecs[5] = '{"gray_max", 2'd2, 8'h00, 24'hFFFFFF, 24'hFFFFFF};
        vecs[6] = '{"gray_low", 2'd2, 8'h00, 24'h010203, 24'h020202};
        vecs[7] = '{"thr_zero", 2'd3, 8'h00, 24'h000000, 24'hFFFFFF};
        for (int v = 0; v < 8; v++) begin
            pix_a[0] = vecs[v].pix;
            exp_a[0] = vecs[v].expv;
            run_frame(1, 1, vecs[v].md, vecs[v].thr, 0, 0, 0);
            step();
        end

        // Backpressure over a 3x3 inverted frame
        for (int i = 0; i < 9; i++) begin
            pix_a[i] = 24'(i) * 24'h111111;
            exp_a[i] = ~pix_a[i];
        end
        run_frame(3, 3, 2'd1, 8'd0, 1, 0, 0);

        // en freeze mid-frame
        for (int i = 0; i < 8; i++) begin
            pix_a[i] = 24'h000010 + 24'(i);
            exp_a[i] = pix_a[i];
        end
        run_frame(4, 2, 2'd0, 8'd0, 0, 1, 0);

        // Zero-dimension starts are ignored
        cfg_width = 16'd0;
        cfg_height = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        #1;
        check("zero_width_busy", busy, 1'b0);
        check("zero_width_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        cfg_width = 16'd2;
        cfg_height = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_height_busy", busy, 1'b0);

        // Start and mode change during RUN are ignored
        for (int i = 0; i < 6; i++) begin
            pix_a[i] = 24'h102030 + 24'(i);
            exp_a[i] = pix_a[i];
        end
        run_frame(3, 2, 2'd0, 8'd0, 0, 0, 1);

        // Reset mid-frame, then a 1x1 frame
        mode = 2'd0;
        cfg_width = 16'd4;
        cfg_height = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 24'h0000A0 + 24'(i);
            step();
        end
        check("pre_reset_out_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        step();
        #1;
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_in_ready", in_ready, 1'b0);
        reset_n = 1'b1;
        in_valid = 1'b0;
        step();
        pix_a[0] = 24'h123456;
        exp_a[0] = 24'h123456;
        run_frame(1, 1, 2'd0, 8'd0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
